pet_action_scheduler: RTL and testbench

Sequences the pet's care actions from the debounced button signals produced by the button driver: food, heal and test.
- Detects presses and latches one pending request per source.
- Arbitrates food vs heal round-robin, applies the action to the stat registers, then enforces a cooldown.
- Decays the stats on a periodic tick and derives the pet mood; test mode accelerates all timing.
- Outputs feed the display and LED blocks.

---
 rtl/pet_pkg.sv | 43 ++++
 rtl/pet_tick_gen.sv | 38 +++
 rtl/pet_action_scheduler.sv | 171 +++++++++++++++++
 tb/tb_pet_action_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// Shared types and helpers for the pet care blocks: mood and FSM encodings,
// default stat ceiling and the saturating add/sub used on every stat.
package pet_pkg;

  localparam int LVL_MAX_DEF = 7;
  localparam int SAT_W       = 16;

  typedef enum logic [1:0] {
    MOOD_HAPPY  = 2'b00,
    MOOD_HUNGRY = 2'b01,
    MOOD_SICK   = 2'b10,
    MOOD_DEAD   = 2'b11
  } mood_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FEED = 3'd1,
    ST_HEAL = 3'd2,
    ST_COOL = 3'd3,
    ST_DEAD = 3'd4
  } state_e;

  typedef enum logic {
    SRC_FOOD = 1'b0,
    SRC_HEAL = 1'b1
  } src_e;

  // Result is clamped to [0, max]; one extra bit keeps the add carry visible.
  function automatic logic [SAT_W-1:0] sat_addsub(input logic [SAT_W-1:0] a,
                                                  input logic [SAT_W-1:0] b,
                                                  input logic             sub,
                                                  input logic [SAT_W-1:0] max);
    logic [SAT_W:0] r;
    if (sub) begin
      r = (a >= b) ? {1'b0, a - b} : '0;
    end else begin
      r = {1'b0, a} + {1'b0, b};
      if (r > {1'b0, max}) r = {1'b0, max};
    end
    return r[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Decay prescaler: one-cycle tick every CLK_HZ*TICK_SEC cycles, or a
// TEST_DIV-times shorter period while test mode is on.
module pet_tick_gen #(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_SEC = 10,
  parameter int TEST_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic test_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int P_RAW  = CLK_HZ * TICK_SEC;
  localparam int P_NORM = (P_RAW < 1) ? 1 : P_RAW;
  localparam int P_TEST = (P_NORM / TEST_DIV < 1) ? 1 : P_NORM / TEST_DIV;
  localparam int TW     = (P_NORM > 1) ? $clog2(P_NORM) : 1;

  logic [TW-1:0] cnt_q, cnt_d, term;

  assign term   = test_i ? TW'(P_TEST - 1) : TW'(P_NORM - 1);
  // >= rather than == so a count left over from the long period still wraps.
  assign tick_o = en_i & ~clr_i & (cnt_q >= term);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q >= term) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pet_action_scheduler.sv
// Pet action scheduler: button press latching, round-robin food/heal service
// with cooldown, periodic stat decay and registered mood.
module pet_action_scheduler import pet_pkg::*; #(
  parameter int CLK_HZ       = 50000000,
  parameter int TICK_SEC     = 10,
  parameter int TEST_DIV     = 10,
  parameter int COOLDOWN_CYC = 25000000,
  parameter int LVL_MAX      = LVL_MAX_DEF,
  parameter int STEP         = 2,
  localparam int W           = $clog2(LVL_MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         food_n,
  input  logic         heal_n,
  input  logic         test_n,
  output logic [W-1:0] food_lvl,
  output logic [W-1:0] health_lvl,
  output logic [1:0]   mood,
  output logic         busy,
  output logic         ack_food,
  output logic         ack_heal,
  output logic         test_active
);

  localparam int COOL_NORM = (COOLDOWN_CYC < 1) ? 1 : COOLDOWN_CYC;
  localparam int COOL_TEST = (COOL_NORM / TEST_DIV < 1) ? 1 : COOL_NORM / TEST_DIV;
  localparam int CW        = $clog2(COOL_NORM + 1);
  localparam logic [W:0] LOW_THR = (W + 1)'(2);

  state_e        state_q, state_d;
  src_e          last_q, last_d;
  mood_e         mood_q, mood_d;
  logic          food_prev_q, heal_prev_q, test_prev_q;
  logic          food_press, heal_press, test_press;
  logic          pend_food_q, pend_food_d, pend_heal_q, pend_heal_d;
  logic          test_q;
  logic [CW-1:0] cool_q, cool_d, cool_term;
  logic [W-1:0]  food_q, food_d, food_dec, health_q, health_d, health_dec;
  logic          tick;

  assign food_press = food_prev_q & ~food_n;
  assign heal_press = heal_prev_q & ~heal_n;
  assign test_press = test_prev_q & ~test_n;

  pet_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_SEC(TICK_SEC),
    .TEST_DIV(TEST_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q != ST_DEAD),
    .test_i(test_q),
    .clr_i (test_press),
    .tick_o(tick)
  );

  // Decay first, then the action's add lands on the decayed value.
  always_comb begin
    food_dec   = food_q;
    health_dec = health_q;
    if (tick) begin
      food_dec = W'(sat_addsub(SAT_W'(food_q), SAT_W'(1), 1'b1, SAT_W'(LVL_MAX)));
      if (food_q == '0)
        health_dec = W'(sat_addsub(SAT_W'(health_q), SAT_W'(1), 1'b1, SAT_W'(LVL_MAX)));
    end
    food_d   = food_dec;
    health_d = health_dec;
    if (state_q == ST_FEED)
      food_d = W'(sat_addsub(SAT_W'(food_dec), SAT_W'(STEP), 1'b0, SAT_W'(LVL_MAX)));
    if (state_q == ST_HEAL)
      health_d = W'(sat_addsub(SAT_W'(health_dec), SAT_W'(STEP), 1'b0, SAT_W'(LVL_MAX)));
  end

  assign cool_term = test_q ? CW'(COOL_TEST - 1) : CW'(COOL_NORM - 1);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cool_d  = cool_q;
    case (state_q)
      ST_IDLE: begin
        if (health_q == '0)                 state_d = ST_DEAD;
        else if (pend_food_q && pend_heal_q) state_d = (last_q == SRC_HEAL) ? ST_FEED : ST_HEAL;
        else if (pend_food_q)               state_d = ST_FEED;
        else if (pend_heal_q)               state_d = ST_HEAL;
      end
      ST_FEED: begin
        last_d  = SRC_FOOD;
        cool_d  = '0;
        state_d = ST_COOL;
      end
      ST_HEAL: begin
        last_d  = SRC_HEAL;
        cool_d  = '0;
        state_d = ST_COOL;
      end
      ST_COOL: begin
        if (health_d == '0) begin
          state_d = ST_DEAD;
        end else if (cool_q >= cool_term) begin
          state_d = ST_IDLE;
          cool_d  = '0;
        end else begin
          cool_d  = cool_q + 1'b1;
        end
      end
      ST_DEAD: state_d = ST_DEAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // A press on an already-set bit is simply absorbed; serving clears it.
  always_comb begin
    pend_food_d = pend_food_q | food_press;
    pend_heal_d = pend_heal_q | heal_press;
    if (state_q == ST_FEED) pend_food_d = 1'b0;
    if (state_q == ST_HEAL) pend_heal_d = 1'b0;
    if (state_d == ST_DEAD) begin
      pend_food_d = 1'b0;
      pend_heal_d = 1'b0;
    end
  end

  always_comb begin
    mood_d = MOOD_HAPPY;
    if (health_d == '0)                    mood_d = MOOD_DEAD;
    else if ({1'b0, health_d} <= LOW_THR)  mood_d = MOOD_SICK;
    else if ({1'b0, food_d} <= LOW_THR)    mood_d = MOOD_HUNGRY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      last_q      <= SRC_HEAL;
      mood_q      <= MOOD_HAPPY;
      food_prev_q <= 1'b1;
      heal_prev_q <= 1'b1;
      test_prev_q <= 1'b1;
      pend_food_q <= 1'b0;
      pend_heal_q <= 1'b0;
      test_q      <= 1'b0;
      cool_q      <= '0;
      food_q      <= W'(LVL_MAX);
      health_q    <= W'(LVL_MAX);
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mood_q      <= mood_d;
      food_prev_q <= food_n;
      heal_prev_q <= heal_n;
      test_prev_q <= test_n;
      pend_food_q <= pend_food_d;
      pend_heal_q <= pend_heal_d;
      test_q      <= test_q ^ test_press;
      cool_q      <= cool_d;
      food_q      <= food_d;
      health_q    <= health_d;
    end
  end

  assign food_lvl    = food_q;
  assign health_lvl  = health_q;
  assign mood        = mood_q;
  assign busy        = (state_q == ST_FEED) || (state_q == ST_HEAL) || (state_q == ST_COOL);
  assign ack_food    = (state_q == ST_FEED);
  assign ack_heal    = (state_q == ST_HEAL);
  assign test_active = test_q;

endmodule

// File: tb/tb_pet_action_scheduler.sv
// Directed bench for pet_action_scheduler: table of press/wait/expect vectors
// plus hand sequences for arbitration, cooldown, tick collision and reset.
module tb_pet_action_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       food_n = 1'b1, heal_n = 1'b1, test_n = 1'b1;
  logic [2:0] food_lvl, health_lvl;
  logic [1:0] mood;
  logic       busy, ack_food, ack_heal, test_active;

  int n_tests = 0;
  int n_fail  = 0;
  int af_cnt  = 0;
  int ah_cnt  = 0;

  pet_action_scheduler #(
    .CLK_HZ(100), .TICK_SEC(1), .TEST_DIV(10), .COOLDOWN_CYC(20), .LVL_MAX(7), .STEP(2)
  ) dut (
    .clk(clk), .rst(rst), .food_n(food_n), .heal_n(heal_n), .test_n(test_n),
    .food_lvl(food_lvl), .health_lvl(health_lvl), .mood(mood), .busy(busy),
    .ack_food(ack_food), .ack_heal(ack_heal), .test_active(test_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      af_cnt <= 0;
      ah_cnt <= 0;
    end else begin
      if (ack_food) af_cnt <= af_cnt + 1;
      if (ack_heal) ah_cnt <= ah_cnt + 1;
    end
  end

  typedef struct {
    bit rst_first;
    bit pf, ph, pt;
    int wt;
    int e_food, e_health, e_mood, e_busy, e_test, e_af, e_ah;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves time at 1 unit after the first edge with reset released.
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    food_n = 1'b1; heal_n = 1'b1; test_n = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    vt[0]  = '{0,0,0,0, 98,  7,7,0,0,0,0,0};
    vt[1]  = '{0,0,0,0, 0,   6,7,0,0,0,0,0};
    vt[2]  = '{0,0,0,0, 599, 0,7,1,0,0,0,0};
    vt[3]  = '{0,0,0,0, 99,  0,6,1,0,0,0,0};
    vt[4]  = '{0,0,0,0, 399, 0,2,2,0,0,0,0};
    vt[5]  = '{0,0,0,0, 199, 0,0,3,0,0,0,0};
    vt[6]  = '{0,1,1,0, 29,  0,0,3,0,0,0,0};
    vt[7]  = '{0,0,0,1, 0,   0,0,3,0,1,0,0};
    vt[8]  = '{1,0,0,1, 0,   7,7,0,0,1,0,0};
    vt[9]  = '{0,0,0,0, 28,  5,7,0,0,1,0,0};
    vt[10] = '{0,0,0,0, 0,   4,7,0,0,1,0,0};
    vt[11] = '{0,0,0,1, 0,   4,7,0,0,0,0,0};
    vt[12] = '{0,0,0,0, 98,  4,7,0,0,0,0,0};
    vt[13] = '{0,0,0,0, 0,   3,7,0,0,0,0,0};

    // Reset state while rst is held low from time 0
    #12;
    check("rst food",   food_lvl, 7);
    check("rst health", health_lvl, 7);
    check("rst mood",   mood, 0);
    check("rst busy",   busy, 0);
    check("rst test",   test_active, 0);
    check("rst acks",   {ack_food, ack_heal}, 0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (vt[i].rst_first) do_reset();
      food_n = ~vt[i].pf; heal_n = ~vt[i].ph; test_n = ~vt[i].pt;
      step(1);
      food_n = 1'b1; heal_n = 1'b1; test_n = 1'b1;
      step(vt[i].wt);
      check($sformatf("v%0d food", i),   food_lvl,    vt[i].e_food);
      check($sformatf("v%0d health", i), health_lvl,  vt[i].e_health);
      check($sformatf("v%0d mood", i),   mood,        vt[i].e_mood);
      check($sformatf("v%0d busy", i),   busy,        vt[i].e_busy);
      check($sformatf("v%0d test", i),   test_active, vt[i].e_test);
      check($sformatf("v%0d ackf", i),   af_cnt,      vt[i].e_af);
      check($sformatf("v%0d ackh", i),   ah_cnt,      vt[i].e_ah);
    end

    // Simultaneous food+heal: food first, heal after cooldown, extra presses collapse
    do_reset();
    food_n = 1'b0; heal_n = 1'b0;
    step(1);
    food_n = 1'b1; heal_n = 1'b1;
    step(1);
    check("rr ack_food first", ack_food, 1);
    check("rr ack_heal not yet", ack_heal, 0);
    check("rr busy in feed", busy, 1);
    step(20);
    check("rr busy end cool", busy, 1);
    step(1);
    check("rr idle gap", busy, 0);
    step(1);
    check("rr ack_heal second", ack_heal, 1);
    for (int k = 0; k < 3; k++) begin
      food_n = 1'b0;
      step(1);
      food_n = 1'b1;
      step(1);
    end
    step(70);
    check("rr ackf total", af_cnt, 2);
    check("rr ackh total", ah_cnt, 1);
    check("rr food after tick", food_lvl, 6);

    // Saturation at LVL_MAX
    do_reset();
    step(100);
    check("sat food 6", food_lvl, 6);
    food_n = 1'b0;
    step(1);
    food_n = 1'b1;
    step(1);
    check("sat ack", ack_food, 1);
    step(1);
    check("sat food 7", food_lvl, 7);

    // FEED on a tick cycle in test mode, then the short cooldown
    do_reset();
    test_n = 1'b0;
    step(1);
    test_n = 1'b1;
    check("coll test on", test_active, 1);
    step(60);
    check("coll food 1", food_lvl, 1);
    step(7);
    food_n = 1'b0;
    step(1);
    food_n = 1'b1;
    step(1);
    check("coll ack", ack_food, 1);
    check("coll food pre", food_lvl, 1);
    step(1);
    check("coll food 2", food_lvl, 2);
    check("coll busy c0", busy, 1);
    step(1);
    check("coll busy c1", busy, 1);
    step(1);
    check("coll cool done", busy, 0);

    // Async reset during COOLDOWN drops the pending heal
    do_reset();
    food_n = 1'b0; heal_n = 1'b0;
    step(1);
    food_n = 1'b1; heal_n = 1'b1;
    step(2);
    test_n = 1'b0;
    step(1);
    test_n = 1'b1;
    check("mid busy", busy, 1);
    check("mid test", test_active, 1);
    rst = 1'b0;
    #2;
    check("async busy", busy, 0);
    check("async test", test_active, 0);
    check("async food", food_lvl, 7);
    check("async health", health_lvl, 7);
    check("async mood", mood, 0);
    check("async acks", {ack_food, ack_heal}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(40);
    check("post rst ackh", ah_cnt, 0);
    check("post rst ackf", af_cnt, 0);
    check("post rst busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
